matvec8_collect: RTL

MATVEC8_COLLECT -- requirements
Module: matvec8_collect

---
 rtl/matvec8_collect.sv | 94 +++++++++
 1 files changed

// File: rtl/matvec8_collect.sv
// Gathers eight signed 28-bit result elements into one packed vector and holds it until taken.
// Define MATVEC8_ARGMAX_EN to also track the argmax of each vector; otherwise the max ports read 0.
module matvec8_collect (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [27:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [223:0] out_vector,
  output logic [2:0]   out_max_idx,
  output logic [27:0]  out_max_val
);

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e         state_q;
  logic [2:0]     cnt_q;
  logic [223:0]   vec_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           accept;

  assign accept = in_valid && in_ready_q;

  // Slots beyond cnt keep the previous vector's contents until overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      cnt_q       <= 3'd0;
      vec_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            for (int i = 0; i < 8; i++) begin
              if (cnt_q == 3'(i)) vec_q[i*28 +: 28] <= in_data;
            end
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= COLLECT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= COLLECT;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_vector = vec_q;

`ifdef MATVEC8_ARGMAX_EN
  logic [2:0]  maxIdx_q;
  logic [27:0] maxVal_q;

  // Element 0 seeds the running max; later elements win only when strictly greater.
  always_ff @(posedge clk) begin
    if (reset) begin
      maxIdx_q <= 3'd0;
      maxVal_q <= 28'd0;
    end else if (accept) begin
      if ((cnt_q == 3'd0) || ($signed(in_data) > $signed(maxVal_q))) begin
        maxIdx_q <= cnt_q;
        maxVal_q <= in_data;
      end
    end
  end

  assign out_max_idx = maxIdx_q;
  assign out_max_val = maxVal_q;
`else
  assign out_max_idx = 3'd0;
  assign out_max_val = 28'd0;
`endif

endmodule
